// File: rtl/hiscore_ram_port.sv
// rtl/hiscore_ram_port.sv - high-score RAM port arbiter between CPU and high-score initiator
// The initiator is granted the RAM only after the CPU is paused and its bus cycle has drained.
module hiscore_ram_port #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk_49m,
  input  logic          reset,
  input  logic          pause_n,
  input  logic          cpu_cen,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  input  logic          hs_access,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_grant,
  output logic          hs_abort,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_GRANT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_hs_write_q;
  logic          r_hs_abort;
  logic [DW-1:0] r_cpu_dout;
  logic [DW-1:0] r_hs_data_out;
  logic          w_grant_sel;
  logic          w_hs_wr_edge;
  logic          w_ram_we;
  logic          w_abort_set;

  // Mux select comes only from the state register so no input can glitch the RAM path.
  assign w_grant_sel  = (r_state == S_GRANT);
  assign w_hs_wr_edge = hs_write & ~r_hs_write_q;

  always_comb begin
    w_state_nxt = r_state;
    w_ram_we    = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ram_we = cpu_we & cpu_cen;
        if (hs_access && !pause_n) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!hs_access || pause_n) w_state_nxt = S_IDLE;
        else if (cpu_cen)          w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // CPU resuming wins over a still-requesting initiator and kills any write.
        if (pause_n) begin
          w_state_nxt = S_IDLE;
          w_abort_set = 1'b1;
        end else if (!hs_access) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ram_we = w_hs_wr_edge;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_hs_write_q  <= 1'b0;
      r_hs_abort    <= 1'b0;
      r_cpu_dout    <= '0;
      r_hs_data_out <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_hs_write_q <= hs_write;
      r_hs_abort   <= w_abort_set;
      if (r_state == S_IDLE)  r_cpu_dout    <= ram_dout;
      if (r_state == S_GRANT) r_hs_data_out <= ram_dout;
    end
  end

  assign ram_addr    = w_grant_sel ? hs_address : cpu_addr;
  assign ram_din     = w_grant_sel ? hs_data_in : cpu_din;
  assign ram_we      = w_ram_we;
  assign cpu_dout    = r_cpu_dout;
  assign hs_data_out = r_hs_data_out;
  assign hs_grant    = w_grant_sel;
  assign hs_abort    = r_hs_abort;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// tb/tb_hiscore_ram_port.sv - directed and randomized bench for hiscore_ram_port
// Holds a 1-cycle-latency RAM and an expected-contents array updated from intended writes.
module tb_hiscore_ram_port;

  logic        clk_49m = 1'b0;
  logic        reset = 1'b0;
  logic        pause_n = 1'b0;
  logic        cpu_cen = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_dout;
  logic        hs_access = 1'b0;
  logic [11:0] hs_address = '0;
  logic [7:0]  hs_data_in = '0;
  logic        hs_write = 1'b0;
  logic [7:0]  hs_data_out;
  logic        hs_grant;
  logic        hs_abort;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = '0;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  int          n_checks = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  int          grant_cnt = 0;
  logic [7:0]  exp_cpu_dout;

  hiscore_ram_port #(.AW(12), .DW(8)) dut (
    .clk_49m(clk_49m), .reset(reset), .pause_n(pause_n),
    .cpu_cen(cpu_cen), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_dout(cpu_dout), .hs_access(hs_access), .hs_address(hs_address),
    .hs_data_in(hs_data_in), .hs_write(hs_write), .hs_data_out(hs_data_out),
    .hs_grant(hs_grant), .hs_abort(hs_abort), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_49m = ~clk_49m;

  always @(posedge clk_49m) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
    if (ram_we) we_cnt++;
    if (hs_grant) grant_cnt++;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1; cpu_cen = 1'b1;
    #1 chk("cpu_write_we", {11'd0, ram_we}, 12'd1);
    tick();
    cpu_we = 1'b0; cpu_cen = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic cpu_read(input logic [11:0] a);
    cpu_addr = a; cpu_we = 1'b0; cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    tick();
    chk("cpu_read", {4'd0, cpu_dout}, {4'd0, ref_mem[a]});
    exp_cpu_dout = ref_mem[a];
  endtask

  task automatic enter_grant(input int waits);
    int g0;
    hs_access = 1'b1; pause_n = 1'b0; cpu_cen = 1'b0; hs_write = 1'b0;
    tick();
    g0 = grant_cnt;
    repeat (waits) tick();
    chk("drain_no_grant", {11'd0, hs_grant}, 12'd0);
    cpu_cen = 1'b1; cpu_we = 1'b1; cpu_din = ~ref_mem[cpu_addr];
    #1 chk("drain_we_blocked", {11'd0, ram_we}, 12'd0);
    tick();
    cpu_cen = 1'b0; cpu_we = 1'b0;
    chk("grant_rise", {11'd0, hs_grant}, 12'd1);
    chk("grant_not_early", 12'(grant_cnt - g0), 12'd0);
  endtask

  task automatic hs_read(input logic [11:0] a);
    hs_address = a; hs_write = 1'b0;
    tick();
    tick();
    chk("hs_read", {4'd0, hs_data_out}, {4'd0, ref_mem[a]});
  endtask

  task automatic hs_write_op(input logic [11:0] a, input logic [7:0] d, input int hold);
    int w0;
    hs_address = a; hs_data_in = d; hs_write = 1'b1;
    #1 chk("hs_write_first_we", {11'd0, ram_we}, 12'd1);
    w0 = we_cnt;
    repeat (hold) tick();
    hs_write = 1'b0;
    tick();
    chk("hs_write_one_pulse", 12'(we_cnt - w0), 12'd1);
    ref_mem[a] = d;
  endtask

  task automatic release_grant();
    int w0;
    hs_access = 1'b0; hs_write = 1'b1;
    hs_address = 12'h3A5; hs_data_in = 8'hEE;
    #1 chk("release_no_we", {11'd0, ram_we}, 12'd0);
    w0 = we_cnt;
    tick();
    hs_write = 1'b0;
    chk("release_grant_low", {11'd0, hs_grant}, 12'd0);
    chk("release_no_write", 12'(we_cnt - w0), 12'd0);
  endtask

  initial begin
    int g0;
    int w0;
    logic [11:0] ra;
    logic [7:0]  rd;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end

    repeat (3) tick();
    chk("rst_cpu_dout", {4'd0, cpu_dout}, 12'd0);
    chk("rst_hs_data_out", {4'd0, hs_data_out}, 12'd0);
    chk("rst_grant", {11'd0, hs_grant}, 12'd0);
    chk("rst_abort", {11'd0, hs_abort}, 12'd0);
    chk("rst_ram_we", {11'd0, ram_we}, 12'd0);
    reset = 1'b1;
    tick();

    // CPU owns the port while not paused, even with the initiator requesting.
    pause_n = 1'b1; hs_access = 1'b1;
    g0 = grant_cnt;
    cpu_write(12'h123, 8'h5A);
    cpu_read(12'h123);
    cpu_write(12'h0FF, 8'hC3);
    cpu_read(12'h123);
    chk("cpu_only_no_grant", 12'(grant_cnt - g0), 12'd0);
    hs_access = 1'b0;
    tick();

    enter_grant(7);
    hs_read(12'h0FF);
    chk("cpu_dout_frozen", {4'd0, cpu_dout}, {4'd0, exp_cpu_dout});
    hs_write_op(12'h200, 8'h11, 5);
    hs_read(12'h200);
    release_grant();
    cpu_read(12'h200);

    // Back-to-back request, write on the very first GRANT cycle.
    enter_grant(2);
    hs_write_op(12'h7E1, 8'h4D, 1);
    hs_read(12'h7E1);

    // Abort: pause_n rises with a write edge in the same cycle.
    hs_address = 12'h0FF; hs_data_in = 8'h77; hs_write = 1'b1; pause_n = 1'b1;
    #1 chk("abort_no_we", {11'd0, ram_we}, 12'd0);
    chk("abort_not_yet", {11'd0, hs_abort}, 12'd0);
    w0 = we_cnt;
    tick();
    hs_write = 1'b0; hs_access = 1'b0;
    chk("abort_pulse", {11'd0, hs_abort}, 12'd1);
    chk("abort_grant_low", {11'd0, hs_grant}, 12'd0);
    chk("abort_no_write", 12'(we_cnt - w0), 12'd0);
    tick();
    chk("abort_one_cycle", {11'd0, hs_abort}, 12'd0);
    cpu_read(12'h0FF);
    cpu_write(12'h555, 8'hA6);
    cpu_read(12'h555);

    for (int s = 0; s < 8; s++) begin
      ra = 12'($urandom_range(0, 4095));
      rd = 8'($urandom_range(0, 255));
      cpu_write(ra, rd);
      cpu_read(12'($urandom_range(0, 4095)));
      enter_grant(int'($urandom_range(0, 5)));
      for (int k = 0; k < 4; k++) begin
        ra = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 1) == 1) begin
          hs_write_op(ra, 8'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
        end else begin
          hs_read(ra);
        end
      end
      chk("rand_cpu_dout_frozen", {4'd0, cpu_dout}, {4'd0, exp_cpu_dout});
      release_grant();
    end

    // Asynchronous reset in the middle of a GRANT cycle cuts a live write.
    cpu_read(12'h123);
    enter_grant(1);
    hs_read(12'h200);
    hs_address = 12'h400; hs_data_in = 8'h99; hs_write = 1'b1;
    #1 chk("pre_reset_we", {11'd0, ram_we}, 12'd1);
    #1 reset = 1'b0;
    #1 chk("areset_grant", {11'd0, hs_grant}, 12'd0);
    chk("areset_ram_we", {11'd0, ram_we}, 12'd0);
    chk("areset_hs_data_out", {4'd0, hs_data_out}, 12'd0);
    chk("areset_cpu_dout", {4'd0, cpu_dout}, 12'd0);
    hs_write = 1'b0; hs_access = 1'b0; pause_n = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    cpu_read(12'h400);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
